// File: rtl/stream_demux_1to2_pkg.sv
// Shared constants for the 1:2 stream demux: FSM state encodings, lane IDs,
// and the one-entry slot acceptance rule used by the top-level ready logic.
package stream_demux_1to2_pkg;

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_LOCKED = 1'b1;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

   // A one-entry slot can take a new beat when empty or draining this cycle.
   function automatic logic lane_can_take(input logic valid, input logic ready);
      return !valid | ready;
   endfunction

endpackage

// File: rtl/stream_demux_1to2_out_reg.sv
// One-entry output register slice for a single demux lane.
// It holds data/last stable while valid is high and the sink is stalled.
module demux_out_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] d_data,
   input  logic              d_last,
   output logic              valid,
   input  logic              ready,
   output logic [DATA_W-1:0] q_data,
   output logic              q_last
);

   // The caller only asserts load when the slot is empty or draining,
   // so a load always wins over a drain in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid  <= 1'b0;
         q_data <= '0;
         q_last <= 1'b0;
      end else if (load) begin
         valid  <= 1'b1;
         q_data <= d_data;
         q_last <= d_last;
      end else if (ready) begin
         valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux_1to2.sv
// 1:2 valid/ready byte-stream demux with per-lane output registers and an
// optional packet lock that holds the lane from the first beat to s_last.
module stream_demux_1to2
   import stream_demux_1to2_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int PKT_MODE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   input  logic              sel,
   output logic              m0_valid,
   input  logic              m0_ready,
   output logic [DATA_W-1:0] m0_data,
   output logic              m0_last,
   output logic              m1_valid,
   input  logic              m1_ready,
   output logic [DATA_W-1:0] m1_data,
   output logic              m1_last,
   output logic              busy
);

   logic              state_reg, state_next;
   logic              route_reg, route_next;
   logic              tgt;
   logic              accept;
   logic [1:0]        lane_valid, lane_ready, lane_load, lane_last;
   logic [DATA_W-1:0] lane_data [2];

   assign tgt     = ((PKT_MODE != 0) && (state_reg == ST_LOCKED)) ? route_reg : sel;
   // Only the target lane gates the input; the other lane may be stalled freely.
   assign s_ready = lane_can_take(lane_valid[tgt], lane_ready[tgt]);
   assign accept  = s_valid & s_ready;

   assign lane_ready = {m1_ready, m0_ready};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         assign lane_load[gi] = accept && (tgt == 1'(gi));

         demux_out_reg #(
            .DATA_W (DATA_W)
         ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load   (lane_load[gi]),
            .d_data (s_data),
            .d_last (s_last),
            .valid  (lane_valid[gi]),
            .ready  (lane_ready[gi]),
            .q_data (lane_data[gi]),
            .q_last (lane_last[gi])
         );
      end
   endgenerate

   assign m0_valid = lane_valid[LANE0];
   assign m0_data  = lane_data[LANE0];
   assign m0_last  = lane_last[LANE0];
   assign m1_valid = lane_valid[LANE1];
   assign m1_data  = lane_data[LANE1];
   assign m1_last  = lane_last[LANE1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         route_reg <= LANE0;
      end else begin
         state_reg <= state_next;
         route_reg <= route_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      route_next = route_reg;
      if (PKT_MODE == 0) begin
         state_next = ST_IDLE;
      end else if (accept) begin
         if (state_reg == ST_IDLE) begin
            // Single-beat packets never lock.
            if (!s_last) begin
               state_next = ST_LOCKED;
               route_next = sel;
            end
         end else if (s_last) begin
            state_next = ST_IDLE;
         end
      end
   end

   always_comb begin
      busy = (state_reg == ST_LOCKED);
   end

endmodule
